// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control block: state codes,
// parameter defaults and the Moore output decode used by the FSM.
package stopwatch_ctrl_pkg;

  localparam int unsigned DB_BITS_DEFAULT    = 16;
  localparam int unsigned DB_COUNT_DEFAULT   = 50000;
  localparam int unsigned CLR_CYCLES_DEFAULT = 2;

  // Codes 5..7 are illegal and recover to ST_CLEAR.
  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_RUN   = 3'd2,
    ST_PAUSE = 3'd3,
    ST_LAP   = 3'd4
  } state_e;

  // Control bundle sent to the counter and display path.
  typedef struct packed {
    logic en;
    logic nreset;
    logic hold;
  } ctrl_out_t;

  // Moore decode of a state into the counter/display controls.
  function automatic ctrl_out_t state_outputs(input state_e s);
    ctrl_out_t o;
    o.en     = 1'b0;
    o.nreset = 1'b1;
    o.hold   = 1'b0;
    case (s)
      ST_CLEAR: o.nreset = 1'b0;
      ST_RUN:   o.en     = 1'b1;
      ST_LAP: begin
        o.en   = 1'b1;
        o.hold = 1'b1;
      end
      default: ;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/stopwatch_ctrl_btn_debounce.sv
// Button conditioning: 2-flop synchronizer, debounce filter, rising-edge detect.
// Ports:
//   NEclk  in  clock, falling-edge active
//   Nreset in  synchronous active-low reset
//   btn    in  raw asynchronous button, active high
//   ev_c   out one-cycle pulse on a debounced 0->1 transition
module stopwatch_ctrl_btn_debounce
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DB_BITS  = DB_BITS_DEFAULT,
  parameter int unsigned DB_COUNT = DB_COUNT_DEFAULT
) (
  input  logic NEclk,
  input  logic Nreset,
  input  logic btn,
  output logic ev_c
);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               level_q, level_d;
  logic               prev_q,  prev_d;
  logic [DB_BITS-1:0] cnt_q,   cnt_d;

  // Debounced level flips after DB_COUNT consecutive disagreeing samples.
  always_comb begin
    sync1_d = btn;
    sync2_d = sync1_q;
    level_d = level_q;
    prev_d  = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == DB_BITS'(DB_COUNT - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + DB_BITS'(1);
      end
    end
  end

  always_ff @(negedge NEclk) begin
    if (!Nreset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
    end
  end

  // Press only; release never produces an event.
  assign ev_c = level_q & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control FSM: turns two raw buttons into counter enable/reset,
// a display-hold flag and a lap capture strobe.
// Ports:
//   NEclk        in  clock, all state updates on the falling edge
//   Nreset       in  synchronous active-low reset
//   btn_ss       in  raw start/stop button
//   btn_lr       in  raw lap/reset button
//   count_en     out counter enable
//   count_nreset out counter reset, active low
//   disp_hold    out display shows latched lap value
//   lap_strobe   out one-cycle pulse on entry into LAP from RUN
//   state        out current FSM state code
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned DB_BITS    = DB_BITS_DEFAULT,
  parameter int unsigned DB_COUNT   = DB_COUNT_DEFAULT,
  parameter int unsigned CLR_CYCLES = CLR_CYCLES_DEFAULT
) (
  input  logic       NEclk,
  input  logic       Nreset,
  input  logic       btn_ss,
  input  logic       btn_lr,
  output logic       count_en,
  output logic       count_nreset,
  output logic       disp_hold,
  output logic       lap_strobe,
  output logic [2:0] state
);

  localparam int unsigned CLR_W = (CLR_CYCLES < 1) ? 1 : $clog2(CLR_CYCLES + 1);

  logic ev_ss_c;
  logic ev_lr_c;

  stopwatch_ctrl_btn_debounce #(
    .DB_BITS (DB_BITS),
    .DB_COUNT(DB_COUNT)
  ) u_db_ss (
    .NEclk (NEclk),
    .Nreset(Nreset),
    .btn   (btn_ss),
    .ev_c  (ev_ss_c)
  );

  stopwatch_ctrl_btn_debounce #(
    .DB_BITS (DB_BITS),
    .DB_COUNT(DB_COUNT)
  ) u_db_lr (
    .NEclk (NEclk),
    .Nreset(Nreset),
    .btn   (btn_lr),
    .ev_c  (ev_lr_c)
  );

  state_e           state_q,   state_d;
  logic [CLR_W-1:0] clr_cnt_q, clr_cnt_d;
  ctrl_out_t        outs_q,    outs_d;
  logic             strobe_q,  strobe_d;

  // Next state; clr_cnt counts CLEAR cycles already spent, so entry from
  // another state starts at 1 while reset leaves it at 0 (full run after release).
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_CLEAR: begin
        if (clr_cnt_q >= CLR_W'(CLR_CYCLES)) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      ST_IDLE: begin
        if (ev_ss_c) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (ev_ss_c)      state_d = ST_PAUSE;
        else if (ev_lr_c) state_d = ST_LAP;
      end
      ST_LAP: begin
        if (ev_ss_c)      state_d = ST_PAUSE;
        else if (ev_lr_c) state_d = ST_RUN;
      end
      ST_PAUSE: begin
        if (ev_ss_c) begin
          state_d = ST_RUN;
        end else if (ev_lr_c) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = CLR_W'(1);
        end
      end
      default: begin
        state_d   = ST_CLEAR;
        clr_cnt_d = CLR_W'(1);
      end
    endcase

    // Outputs registered alongside the state so they change on the same edge.
    outs_d   = state_outputs(state_d);
    strobe_d = (state_q == ST_RUN) && (state_d == ST_LAP);
  end

  always_ff @(negedge NEclk) begin
    if (!Nreset) begin
      state_q     <= ST_CLEAR;
      clr_cnt_q   <= '0;
      outs_q.en     <= 1'b0;
      outs_q.nreset <= 1'b0;
      outs_q.hold   <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      outs_q    <= outs_d;
      strobe_q  <= strobe_d;
    end
  end

  assign count_en     = outs_q.en;
  assign count_nreset = outs_q.nreset;
  assign disp_hold    = outs_q.hold;
  assign lap_strobe   = strobe_q;
  assign state        = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: directed scenarios followed by random
// button activity, checked every cycle against a behavioural model.
module tb_stopwatch_ctrl;

  localparam int unsigned DBC  = 4;
  localparam int unsigned CLRC = 2;

  localparam int S_CLEAR = 0;
  localparam int S_IDLE  = 1;
  localparam int S_RUN   = 2;
  localparam int S_PAUSE = 3;
  localparam int S_LAP   = 4;

  logic       NEclk  = 1'b0;
  logic       Nreset = 1'b0;
  logic       btn_ss = 1'b0;
  logic       btn_lr = 1'b0;
  logic       count_en, count_nreset, disp_hold, lap_strobe;
  logic [2:0] state;

  stopwatch_ctrl #(
    .DB_BITS   (16),
    .DB_COUNT  (DBC),
    .CLR_CYCLES(CLRC)
  ) dut (
    .NEclk       (NEclk),
    .Nreset      (Nreset),
    .btn_ss      (btn_ss),
    .btn_lr      (btn_lr),
    .count_en    (count_en),
    .count_nreset(count_nreset),
    .disp_hold   (disp_hold),
    .lap_strobe  (lap_strobe),
    .state       (state)
  );

  always #5 NEclk = ~NEclk;

  typedef struct packed {
    logic [2:0] st;
    logic       en;
    logic       nr;
    logic       hold;
    logic       stb;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;
  bit   stim_done   = 1'b0;

  // Reference model: per button, pin seen two edges late, then a run of
  // DBC consecutive disagreeing samples flips the clean level; an event is
  // the clean level having gone 0 then 1 over the previous two edges.
  bit pipe_a[2];
  bit pipe_b[2];
  bit clean[2];
  bit clean_old[2];
  int disagree[2];
  int m_state     = S_CLEAR;
  int m_clr_left  = CLRC;

  function automatic exp_t expect_for(input int s, input bit stb);
    exp_t e;
    e.st   = 3'(s);
    e.en   = (s == S_RUN) || (s == S_LAP);
    e.nr   = (s != S_CLEAR);
    e.hold = (s == S_LAP);
    e.stb  = stb;
    return e;
  endfunction

  task automatic model_step(input bit rst_n, input bit ss, input bit lr);
    bit   pins[2];
    bit   ev[2];
    int   nxt;
    exp_t e;
    pins[0] = ss;
    pins[1] = lr;
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        pipe_a[b] = 1'b0; pipe_b[b] = 1'b0;
        clean[b] = 1'b0; clean_old[b] = 1'b0; disagree[b] = 0;
      end
      m_state    = S_CLEAR;
      m_clr_left = CLRC;
      e = '0;
      sb.push_back(e);
    end else begin
      for (int b = 0; b < 2; b++) begin
        ev[b] = clean[b] && !clean_old[b];
        clean_old[b] = clean[b];
        disagree[b] = (pipe_b[b] != clean[b]) ? disagree[b] + 1 : 0;
        if (disagree[b] == int'(DBC)) begin
          clean[b]    = pipe_b[b];
          disagree[b] = 0;
        end
        pipe_b[b] = pipe_a[b];
        pipe_a[b] = pins[b];
      end
      nxt = m_state;
      case (m_state)
        S_CLEAR: if (m_clr_left == 0) nxt = S_IDLE; else m_clr_left--;
        S_IDLE:  if (ev[0]) nxt = S_RUN;
        S_RUN:   if (ev[0]) nxt = S_PAUSE; else if (ev[1]) nxt = S_LAP;
        S_LAP:   if (ev[0]) nxt = S_PAUSE; else if (ev[1]) nxt = S_RUN;
        S_PAUSE: begin
          if (ev[0]) nxt = S_RUN;
          else if (ev[1]) begin
            nxt = S_CLEAR;
            m_clr_left = CLRC - 1;
          end
        end
        default: nxt = S_CLEAR;
      endcase
      e = expect_for(nxt, (m_state == S_RUN) && (nxt == S_LAP));
      m_state = nxt;
      sb.push_back(e);
    end
  endtask

  // Drive inputs half a cycle before the falling edge that samples them.
  task automatic tick(input bit rst_n, input bit ss, input bit lr);
    @(posedge NEclk);
    Nreset = rst_n;
    btn_ss = ss;
    btn_lr = lr;
    model_step(rst_n, ss, lr);
  endtask

  task automatic press(input int ss_len, input int lr_len, input int gap);
    int n;
    n = (ss_len > lr_len) ? ss_len : lr_len;
    for (int i = 0; i < n; i++) tick(1'b1, i < ss_len, i < lr_len);
    repeat (gap) tick(1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: one expected entry per falling edge.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(negedge NEclk);
      #1;
      if (sb.size() == 0) begin
        if (!stim_done) begin
          vectors++;
          miscompares++;
          $display("FAIL scoreboard_underflow t=%0t", $time);
        end
      end else begin
        e   = sb.pop_front();
        got = {state, count_en, count_nreset, disp_hold, lap_strobe};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs t=%0t got st=%0d en=%b nr=%b hold=%b stb=%b want st=%0d en=%b nr=%b hold=%b stb=%b",
                   $time, got.st, got.en, got.nr, got.hold, got.stb,
                   e.st, e.en, e.nr, e.hold, e.stb);
        end
      end
    end
  end

  initial begin
    // Reset, then CLEAR for CLRC cycles before IDLE.
    repeat (3) tick(1'b0, 1'b0, 1'b0);
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    press(10, 0, 8);                   // IDLE -> RUN
    press(10, 0, 8);                   // RUN -> PAUSE
    repeat (4) begin                   // glitches: no event
      repeat (3) tick(1'b1, 1'b1, 1'b0);
      repeat (3) tick(1'b1, 1'b0, 1'b0);
    end
    press(6, 0, 8);                    // PAUSE -> RUN
    press(0, 6, 8);                    // RUN -> LAP with strobe
    press(0, 6, 8);                    // LAP -> RUN
    press(6, 0, 8);                    // RUN -> PAUSE
    press(0, 6, 8);                    // PAUSE -> CLEAR -> IDLE
    press(6, 0, 8);                    // IDLE -> RUN
    press(6, 6, 8);                    // both: RUN -> PAUSE, no strobe
    press(6, 0, 8);                    // PAUSE -> RUN
    press(0, 6, 3);                    // RUN -> LAP
    repeat (2) tick(1'b0, 1'b0, 1'b0); // abort from LAP
    repeat (4) tick(1'b1, 1'b0, 1'b0);

    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        repeat ($urandom_range(1, 3))
          tick(1'b0, bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
      end else begin
        press(int'($urandom_range(0, 10)), int'($urandom_range(0, 10)),
              int'($urandom_range(0, 9)));
      end
    end
    repeat (4) tick(1'b1, 1'b0, 1'b0);
    stim_done = 1'b1;

    for (int w = 0; w < 10 && sb.size() != 0; w++) @(posedge NEclk);
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL scoreboard_drain left=%0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
